// File: rtl/ethernet_mac_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ethernet_mac_tx_fifo : store-and-forward byte FIFO ahead of the MAC; frames
// marked bad by s_tuser or longer than MAX_FRAME_LENGTH are discarded.
// Revision : 1.0
// ----------------------------------------------------------------------------
module ethernet_mac_tx_fifo #(
    parameter int DEPTH            = 2048,
    parameter int MAX_FRAME_LENGTH = 1514
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic       s_tuser,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       m_tuser,
    output logic       drop_err,
    output logic       drop_len
);
    localparam int              c_aw      = $clog2(DEPTH);
    localparam int              c_pw      = c_aw + 1;
    localparam logic [c_pw-1:0] c_depth   = c_pw'(DEPTH);
    localparam logic [10:0]     c_cnt_max = 11'h7FF;

    generate
        if (MAX_FRAME_LENGTH > DEPTH) begin : g_len_check
            $error("MAX_FRAME_LENGTH must not exceed DEPTH");
        end
        if ((1 << c_aw) != DEPTH) begin : g_depth_check
            $error("DEPTH must be a power of 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_t;

    logic [8:0]      mem [DEPTH];
    wr_state_t       state_q, state_d;
    logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_pw-1:0] wr_commit_q, wr_commit_d;
    logic [c_pw-1:0] commit_rd_q, commit_rd_d;
    logic [c_pw-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
    logic [10:0]     cnt_q, cnt_d;
    logic            kind_err_q, kind_err_d;
    logic            ready_en_q, ready_en_d;
    logic [7:0]      m_tdata_q, m_tdata_d;
    logic            m_tlast_q, m_tlast_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            drop_err_q, drop_err_d;
    logic            drop_len_q, drop_len_d;

    logic            w_full;
    logic            w_s_fire;
    logic            w_mem_we;
    logic            w_fetch_en;
    logic [10:0]     w_cnt_next;
    logic            w_len_bad;
    logic [8:0]      w_rd_word;

    // rd_ptr only advances on the output handshake, so the byte parked in the
    // output register still occupies its slot and full reflects undelivered data.
    always_comb begin
        w_full     = (wr_ptr_q - rd_ptr_q) == c_depth;
        s_tready   = ready_en_q && ((state_q == ST_DROP) || !w_full);
        w_s_fire   = s_tvalid && s_tready;
        w_cnt_next = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 11'd1;
        w_len_bad  = {21'd0, w_cnt_next} > 32'(MAX_FRAME_LENGTH);
        ready_en_d = 1'b1;

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        cnt_d       = cnt_q;
        kind_err_d  = kind_err_q;
        w_mem_we    = 1'b0;
        drop_err_d  = 1'b0;
        drop_len_d  = 1'b0;

        if (w_s_fire) begin
            if (state_q == ST_DROP) begin
                kind_err_d = kind_err_q || s_tuser;
                if (s_tlast) begin
                    state_d    = ST_IDLE;
                    drop_err_d = kind_err_d;
                    drop_len_d = !kind_err_d;
                end
            end else if (s_tuser || w_len_bad) begin
                wr_ptr_d   = wr_commit_q;
                cnt_d      = '0;
                kind_err_d = s_tuser;
                if (s_tlast) begin
                    state_d    = ST_IDLE;
                    drop_err_d = s_tuser;
                    drop_len_d = !s_tuser;
                end else begin
                    state_d = ST_DROP;
                end
            end else begin
                w_mem_we = 1'b1;
                wr_ptr_d = wr_ptr_q + c_pw'(1);
                if (s_tlast) begin
                    wr_commit_d = wr_ptr_d;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d   = w_cnt_next;
                    state_d = ST_WRITE;
                end
            end
        end
    end

    // The read side sees the commit pointer one cycle late, giving the
    // two-edge commit-to-valid latency.
    always_comb begin
        commit_rd_d = wr_commit_q;
        w_rd_word   = mem[fetch_ptr_q[c_aw-1:0]];
        w_fetch_en  = (fetch_ptr_q != commit_rd_q) && (!m_tvalid_q || m_tready);
        rd_ptr_d    = rd_ptr_q + c_pw'(m_tvalid_q && m_tready);
        fetch_ptr_d = fetch_ptr_q;
        m_tdata_d   = m_tdata_q;
        m_tlast_d   = m_tlast_q;
        m_tvalid_d  = m_tvalid_q;
        if (w_fetch_en) begin
            fetch_ptr_d = fetch_ptr_q + c_pw'(1);
            m_tdata_d   = w_rd_word[7:0];
            m_tlast_d   = w_rd_word[8];
            m_tvalid_d  = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[wr_ptr_q[c_aw-1:0]] <= {s_tlast, s_tdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            commit_rd_q <= '0;
            fetch_ptr_q <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            kind_err_q  <= 1'b0;
            ready_en_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tlast_q   <= 1'b0;
            m_tvalid_q  <= 1'b0;
            drop_err_q  <= 1'b0;
            drop_len_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            commit_rd_q <= commit_rd_d;
            fetch_ptr_q <= fetch_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            kind_err_q  <= kind_err_d;
            ready_en_q  <= ready_en_d;
            m_tdata_q   <= m_tdata_d;
            m_tlast_q   <= m_tlast_d;
            m_tvalid_q  <= m_tvalid_d;
            drop_err_q  <= drop_err_d;
            drop_len_q  <= drop_len_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tuser  = 1'b0;
    assign drop_err = drop_err_q;
    assign drop_len = drop_len_q;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_mac_tx_fifo.sv
`default_nettype none
// tb_ethernet_mac_tx_fifo : directed and randomized frames checked against a
// frame-level reference model (good frames pass in order, bad ones are counted).
module tb_ethernet_mac_tx_fifo;
    localparam int MAXLEN = 1514;

    typedef logic [7:0] bq_t[$];

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] s_tdata  = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast  = 1'b0;
    logic       s_tuser  = 1'b0;
    logic       m_tready = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tlast, m_tuser, drop_err, drop_len;

    int ready_mode = 1;
    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] out_q[$];
    int         out_cyc[$];
    int n_err = 0, n_len = 0, exp_err = 0, exp_len = 0;
    int unstable = 0, tuser_bad = 0;
    int chk_idx = 0;
    logic       prev_hold = 1'b0;
    logic [8:0] prev_word = '0;

    ethernet_mac_tx_fifo #(.DEPTH(2048), .MAX_FRAME_LENGTH(MAXLEN)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .drop_err(drop_err), .drop_len(drop_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) m_tready = 1'($urandom_range(0, 1));
        else                 m_tready = (ready_mode == 1);
    end

    // Output collector: handshake seen at a falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_hold && (!m_tvalid || ({m_tlast, m_tdata} !== prev_word))) unstable++;
            if (m_tvalid && m_tready) begin
                out_q.push_back({m_tlast, m_tdata});
                out_cyc.push_back(cyc);
            end
            if (drop_err === 1'b1) n_err++;
            if (drop_len === 1'b1) n_len++;
            if (m_tuser !== 1'b0) tuser_bad++;
            prev_hold = m_tvalid && !m_tready;
            prev_word = {m_tlast, m_tdata};
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t rand_frame(input int len);
        bq_t f;
        for (int i = 0; i < len; i++) f.push_back(8'($urandom_range(0, 255)));
        return f;
    endfunction

    // Reference model: a frame is either forwarded whole or counted as one drop.
    task automatic model_frame(input bq_t f, input int user_pos);
        if (user_pos >= 0)          exp_err++;
        else if (f.size() > MAXLEN) exp_len++;
        else for (int i = 0; i < f.size(); i++)
            exp_q.push_back({(i == f.size() - 1) ? 1'b1 : 1'b0, f[i]});
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic user, output bit ok);
        int  waited = 0;
        bit  rdy;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 5000);
        ok = rdy;
    endtask

    task automatic send_frame(input bq_t f, input int user_pos, input int upto);
        bit ok = 1'b1;
        for (int i = 0; i < upto && ok; i++)
            send_beat(f[i], (i == f.size() - 1), (i == user_pos), ok);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        check("s_accept", 32'(ok), 32'd1);
    endtask

    task automatic set_ready(input int mode);
        @(negedge clk);
        ready_mode = mode;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_and_compare(input string tag, input int budget);
        int n = 0;
        while (out_q.size() < exp_q.size() && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = chk_idx; i < exp_q.size() && i < out_q.size(); i++)
            check(tag, 32'(out_q[i]), 32'(exp_q[i]));
        while (out_q.size() > exp_q.size()) begin
            void'(out_q.pop_back());
            void'(out_cyc.pop_back());
        end
        while (exp_q.size() > out_q.size()) void'(exp_q.pop_back());
        chk_idx = exp_q.size();
        check({tag, "_drop_err_cnt"}, n_err, exp_err);
        check({tag, "_drop_len_cnt"}, n_len, exp_len);
    endtask

    task automatic check_contig(input string tag, input int from, input int to);
        int gaps = 0;
        for (int i = from + 1; i < to && i < out_cyc.size(); i++)
            if (out_cyc[i] != out_cyc[i-1] + 1) gaps++;
        check(tag, gaps, 0);
    endtask

    initial begin
        bq_t f;
        bq_t g;
        int  start;
        int  len;
        int  upos;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 32'(s_tready), 0);
        check("rst_m_tvalid", 32'(m_tvalid), 0);
        check("rst_m_tlast",  32'(m_tlast), 0);
        check("rst_m_tdata",  32'(m_tdata), 0);
        check("rst_drop_err", 32'(drop_err), 0);
        check("rst_drop_len", 32'(drop_len), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_s_tready_pre_edge", 32'(s_tready), 0);
        @(posedge clk);
        #1;
        check("rel_s_tready_first_edge", 32'(s_tready), 1);

        // 60-byte incrementing frame: latency and contiguity
        f = {};
        for (int i = 0; i < 60; i++) f.push_back(8'(i));
        start = chk_idx;
        send_frame(f, -1, f.size());
        model_frame(f, -1);
        @(negedge clk);
        check("lat_edge1_valid", 32'(m_tvalid), 0);
        @(negedge clk);
        check("lat_edge2_valid_pre", 32'(m_tvalid), 0);
        @(negedge clk);
        check("lat_edge2_valid", 32'(m_tvalid), 1);
        check("lat_first_data", 32'(m_tdata), 0);
        @(posedge clk);
        #1;
        drain_and_compare("f60", 500);
        check_contig("f60_contig", start, start + 60);

        // Errored 100-byte frame then good 64-byte frame
        f = rand_frame(100);
        send_frame(f, 9, f.size());
        model_frame(f, 9);
        @(negedge clk);
        check("err_pulse_drop_err", 32'(drop_err), 1);
        check("err_pulse_drop_len", 32'(drop_len), 0);
        @(posedge clk);
        #1;
        f = rand_frame(64);
        send_frame(f, -1, f.size());
        model_frame(f, -1);
        drain_and_compare("err_then_good", 500);

        // Maximum length frame passes, one byte longer is dropped
        f = rand_frame(MAXLEN);
        send_frame(f, -1, f.size());
        model_frame(f, -1);
        f = rand_frame(MAXLEN + 1);
        send_frame(f, -1, f.size());
        model_frame(f, -1);
        @(negedge clk);
        check("len_pulse_drop_len", 32'(drop_len), 1);
        check("len_pulse_drop_err", 32'(drop_err), 0);
        @(posedge clk);
        #1;
        drain_and_compare("maxlen", 3000);

        // Fill to capacity with the output stalled, then release
        set_ready(0);
        start = chk_idx;
        for (int k = 0; k < 32; k++) begin
            f = rand_frame(64);
            send_frame(f, -1, f.size());
            model_frame(f, -1);
        end
        @(negedge clk);
        check("full_s_tready", 32'(s_tready), 0);
        check("full_m_tvalid", 32'(m_tvalid), 1);
        ready_mode = 1;
        @(negedge clk);
        check("full_s_tready_before_read", 32'(s_tready), 0);
        @(negedge clk);
        check("full_s_tready_after_read", 32'(s_tready), 1);
        @(posedge clk);
        #1;
        drain_and_compare("fill32", 5000);
        check_contig("fill32_contig", start, start + 2048);

        // Reset with two stored frames and a partial one
        set_ready(0);
        f = rand_frame(60);
        send_frame(f, -1, f.size());
        f = rand_frame(60);
        send_frame(f, -1, f.size());
        f = rand_frame(60);
        send_frame(f, -1, 30);
        @(negedge clk);
        check("pre_reset_m_tvalid", 32'(m_tvalid), 1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_m_tvalid", 32'(m_tvalid), 0);
        check("mid_reset_s_tready", 32'(s_tready), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        ready_mode = 1;
        repeat (100) @(posedge clk);
        #1;
        check("post_reset_no_output", out_q.size(), chk_idx);
        check("post_reset_no_err_pulse", n_err, exp_err);
        check("post_reset_no_len_pulse", n_len, exp_len);
        f = rand_frame(60);
        send_frame(f, -1, f.size());
        model_frame(f, -1);
        drain_and_compare("post_reset", 500);

        // 100 mixed frames with random output backpressure
        set_ready(2);
        for (int k = 0; k < 100; k++) begin
            len = ($urandom_range(0, 99) < 4) ? MAXLEN + 1 + int'($urandom_range(0, 15))
                                              : int'($urandom_range(1, 120));
            upos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            g = rand_frame(len);
            send_frame(g, upos, g.size());
            model_frame(g, upos);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        drain_and_compare("mixed", 40000);

        check("hold_stability_violations", unstable, 0);
        check("m_tuser_nonzero", tuser_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ethernet_mac_tx_fifo.md
ETHERNET_MAC_TX_FIFO -- requirements
Module: ethernet_mac_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, FIFO capacity in bytes (power of 2).
REQ-002 SHALL have parameter MAX_FRAME_LENGTH, default 1514, largest accepted frame in bytes (DA+SA+type+payload); elaboration SHALL fail if MAX_FRAME_LENGTH > DEPTH.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 s_tdata  input  8  upstream frame byte.
REQ-007 s_tvalid  input  1  upstream byte valid.
REQ-008 s_tready  output  1  byte accepted when s_tvalid and s_tready are both high.
REQ-009 s_tlast  input  1  last byte of frame.
REQ-010 s_tuser  input  1  error marker; high on any beat marks the frame bad.
REQ-011 m_tdata  output  8  byte to MAC encapsulation stage.
REQ-012 m_tvalid, m_tready, m_tlast  output/input/output  1 each  downstream AXI-Stream handshake.
REQ-013 m_tuser  output  1  tied 0 (bad frames are never forwarded).
REQ-014 drop_err  output  1  one-cycle pulse per frame dropped for s_tuser.
REQ-015 drop_len  output  1  one-cycle pulse per frame dropped for exceeding MAX_FRAME_LENGTH.

Function
REQ-016 SHALL be store-and-forward: no byte of a frame appears on m_* before that frame's tlast beat is accepted and committed.
REQ-017 SHALL store 9 bits per entry (data, last) in DEPTH-entry RAM; pointers wr_ptr, wr_commit, rd_ptr are clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-018 Full = (wr_ptr - rd_ptr) == DEPTH; s_tready = !full, except s_tready = 1 in DROP state.
REQ-019 Write FSM states: IDLE (no partial frame), WRITE (partial frame stored), DROP (discarding rest of bad frame).
REQ-020 IDLE->WRITE on accepted non-last good beat; a good accepted beat with s_tlast in IDLE or WRITE SHALL commit (wr_commit <= wr_ptr+1) and go/stay IDLE.
REQ-021 Per-frame byte counter SHALL count accepted beats, saturating at 2047.
REQ-022 Accepted beat with s_tuser=1, or making byte count > MAX_FRAME_LENGTH, SHALL rewind wr_ptr to wr_commit and, if not s_tlast, enter DROP; s_tuser takes precedence over length for the pulse type.
REQ-023 In DROP, beats SHALL be accepted and discarded; accepted s_tlast returns to IDLE and fires the pulse (drop_err or drop_len) on that edge; a bad beat with s_tlast fires the pulse immediately.
REQ-024 Read side: when rd_ptr != wr_commit and (!m_tvalid or m_tready), RAM SHALL be read and m_tdata/m_tlast/m_tvalid registered on the next edge; otherwise m_tvalid held.
REQ-025 Latency: into an empty FIFO, m_tvalid SHALL rise on the 2nd rising edge after the edge accepting the committing tlast.
REQ-026 Throughput: with m_tready=1 continuously, one byte per clk, including back-to-back frames with no gap.
REQ-027 m_tdata/m_tlast SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-028 Simultaneous write and read in same cycle SHALL both proceed; full is evaluated on the current pointers.

Reset
REQ-029 While reset_n low: all pointers 0, FSM IDLE, counter 0, m_tvalid=0, m_tlast=0, m_tdata=0, drop_err=0, drop_len=0, s_tready=0.
REQ-030 First edge after reset_n rises: s_tready=1; reset mid-frame SHALL discard all stored and partial frames with no output and no drop pulse.

Verification
REQ-031 60-byte frame 0x00..0x3B, m_tready=1 -> m_tvalid rises 2nd edge after tlast, 60 contiguous beats, m_tlast on 0x3B.
REQ-032 100-byte frame with s_tuser on byte 10, then good 64-byte frame -> drop_err pulses once at byte 100, only the 64-byte frame emerges.
REQ-033 1514-byte frame then 1515-byte frame -> first forwarded intact, drop_len pulses once at 1515th beat, nothing else output.
REQ-034 m_tready=0, send 64-byte frames -> s_tready falls after 2048th byte (32 frames); m_tready=1 -> 32 frames out in order, s_tready returns 1 the edge after first read.
REQ-035 reset_n low at byte 30 of 60-byte frame with 2 committed frames stored -> m_tvalid=0, no output after release, next frame passes normally.
REQ-036 m_tready toggled randomly 50% over 100 mixed frames -> output byte stream equals input stream of good frames.
